// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART RX frame controller, its majority sampler and
// the system-side consumer. The controller uses the slave view.
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int COUNTER_WIDTH  = 4
);
  logic                      RX_IN;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      sampled_bit;
  logic                      valid_sampled_bit;
  logic [PRESCALE_WIDTH-1:0] sample_counter;
  logic [COUNTER_WIDTH-1:0]  bit_counter;
  logic                      smp_clear;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      data_valid;
  logic                      parity_error;
  logic                      stop_error;
  logic                      busy;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale, sampled_bit, valid_sampled_bit,
    input  sample_counter, bit_counter, smp_clear, P_DATA, data_valid,
           parity_error, stop_error, busy
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale, sampled_bit, valid_sampled_bit,
    output sample_counter, bit_counter, smp_clear, P_DATA, data_valid,
           parity_error, stop_error, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: start detection, oversampling/bit counters for the
// majority sampler, byte assembly, parity/stop checking and byte presentation.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int COUNTER_WIDTH  = 4
) (
  input  logic CLK,
  input  logic RST,
  uart_rx_ctrl_if.slave rx_if
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]                r_state;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic [PRESCALE_WIDTH-1:0] r_sample_cnt;
  logic [COUNTER_WIDTH-1:0]  r_bit_cnt;
  logic                      r_smp_clear;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic [DATA_WIDTH-1:0]     r_p_data;
  logic                      r_data_valid;
  logic                      r_parity_error;
  logic                      r_stop_error;
  logic                      r_stop_one;

  logic w_bit_end, w_last_data, w_par_exp, w_start_det, w_glitch;
  logic w_frame_done, w_stop_bad, w_stop_good, w_frame_ok;

  assign w_bit_end    = (r_sample_cnt == r_prescale - PRESCALE_WIDTH'(1));
  assign w_last_data  = (r_bit_cnt == COUNTER_WIDTH'(DATA_WIDTH));
  assign w_par_exp    = (^r_shift) ^ r_par_typ;
  assign w_start_det  = (r_state == S_IDLE) && !rx_if.RX_IN;
  assign w_glitch     = (r_state == S_START) && rx_if.valid_sampled_bit && rx_if.sampled_bit;
  assign w_frame_done = (r_state == S_STOP) && w_bit_end;
  assign w_stop_bad   = (r_state == S_STOP) && rx_if.valid_sampled_bit && !rx_if.sampled_bit;
  assign w_stop_good  = (r_state == S_STOP) && rx_if.valid_sampled_bit && rx_if.sampled_bit;
  // A stop sample landing on the final edge still counts toward this frame's verdict.
  assign w_frame_ok   = !r_parity_error && !r_stop_error && !w_stop_bad &&
                        (r_stop_one || w_stop_good);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_smp_clear  <= 1'b1;
    end else begin
      if (r_state == S_IDLE || w_glitch || w_frame_done) begin
        r_sample_cnt <= '0;
        r_bit_cnt    <= '0;
      end else if (w_bit_end) begin
        r_sample_cnt <= '0;
        r_bit_cnt    <= r_bit_cnt + COUNTER_WIDTH'(1);
      end else begin
        r_sample_cnt <= r_sample_cnt + PRESCALE_WIDTH'(1);
      end
      if (w_start_det)
        r_smp_clear <= 1'b0;
      else if (w_glitch || w_frame_done)
        r_smp_clear <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state        <= S_IDLE;
      r_prescale     <= '0;
      r_par_en       <= 1'b0;
      r_par_typ      <= 1'b0;
      r_shift        <= '0;
      r_p_data       <= '0;
      r_data_valid   <= 1'b0;
      r_parity_error <= 1'b0;
      r_stop_error   <= 1'b0;
      r_stop_one     <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_det) begin
            r_state        <= S_START;
            r_prescale     <= rx_if.Prescale;
            r_par_en       <= rx_if.PAR_EN;
            r_par_typ      <= rx_if.PAR_TYP;
            r_parity_error <= 1'b0;
            r_stop_error   <= 1'b0;
            r_stop_one     <= 1'b0;
          end
        end
        S_START: begin
          if (w_glitch)
            r_state <= S_IDLE;
          else if (w_bit_end)
            r_state <= S_DATA;
        end
        S_DATA: begin
          if (rx_if.valid_sampled_bit)
            r_shift <= {rx_if.sampled_bit, r_shift[DATA_WIDTH-1:1]};
          if (w_bit_end && w_last_data)
            r_state <= r_par_en ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          if (rx_if.valid_sampled_bit && (rx_if.sampled_bit != w_par_exp))
            r_parity_error <= 1'b1;
          if (w_bit_end)
            r_state <= S_STOP;
        end
        S_STOP: begin
          if (w_stop_bad)
            r_stop_error <= 1'b1;
          if (w_stop_good)
            r_stop_one <= 1'b1;
          if (w_frame_done) begin
            r_state <= S_IDLE;
            if (w_frame_ok) begin
              r_p_data     <= r_shift;
              r_data_valid <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_if.sample_counter = r_sample_cnt;
  assign rx_if.bit_counter    = r_bit_cnt;
  assign rx_if.smp_clear      = r_smp_clear;
  assign rx_if.P_DATA         = r_p_data;
  assign rx_if.data_valid     = r_data_valid;
  assign rx_if.parity_error   = r_parity_error;
  assign rx_if.stop_error     = r_stop_error;
  assign rx_if.busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: serial frames from a vector table, a simple
// mid-bit sampler model, and hand sequences for glitch, back-to-back and reset.
module tb_uart_rx_ctrl;
  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;
  int   cur_ps = 8;
  int   dv_cnt = 0;
  logic [7:0] cap [16];

  uart_rx_ctrl_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6), .COUNTER_WIDTH(4)) bus ();
  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6), .COUNTER_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .rx_if(bus.slave));

  always #5 CLK = ~CLK;

  // Sampler model: one strobe in the middle of each bit window.
  always @(negedge CLK) begin
    bus.valid_sampled_bit = RST && !bus.smp_clear &&
                            (bus.sample_counter == 6'(cur_ps / 2));
    bus.sampled_bit = bus.RX_IN;
  end

  always @(negedge CLK) begin
    if (bus.data_valid) begin
      cap[dv_cnt % 16] = bus.P_DATA;
      dv_cnt = dv_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input int ps, input logic [7:0] d, input logic pen,
                            input logic pbit, input logic sbit,
                            input int ps_mid, input logic pen_mid);
    cur_ps = ps;
    bus.RX_IN = 1'b0;
    repeat (ps) @(negedge CLK);
    if (ps_mid != 0) begin
      bus.Prescale = 6'(ps_mid);
      bus.PAR_EN   = pen_mid;
    end
    for (int i = 0; i < 8; i++) begin
      bus.RX_IN = d[i];
      repeat (ps) @(negedge CLK);
    end
    if (pen) begin
      bus.RX_IN = pbit;
      repeat (ps) @(negedge CLK);
    end
    bus.RX_IN = sbit;
    repeat (ps) @(negedge CLK);
    bus.RX_IN = 1'b1;
  endtask

  typedef struct {
    int         ps;
    logic [7:0] d;
    logic       pen;
    logic       ptyp;
    logic       pbit;
    logic       sbit;
    int         ps_mid;
    logic       pen_mid;
    int         exp_dv;
    logic [7:0] exp_pd;
    logic       exp_pe;
    logic       exp_se;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int dv0;
    vecs[0] = '{8,  8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0,  1'b0, 1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 0,  1'b0, 1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 0,  1'b0, 0, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{32, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 0,  1'b0, 0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{16, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 8,  1'b1, 1, 8'h7E, 1'b0, 1'b0};
    vecs[5] = '{8,  8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 0,  1'b0, 1, 8'hC3, 1'b0, 1'b0};

    RST = 1'b0;
    bus.RX_IN = 1'b1;
    bus.Prescale = 6'd8;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    #12;
    chk("rst sample_counter", 32'(bus.sample_counter), 0);
    chk("rst bit_counter", 32'(bus.bit_counter), 0);
    chk("rst smp_clear", 32'(bus.smp_clear), 1);
    chk("rst P_DATA", 32'(bus.P_DATA), 0);
    chk("rst data_valid", 32'(bus.data_valid), 0);
    chk("rst parity_error", 32'(bus.parity_error), 0);
    chk("rst stop_error", 32'(bus.stop_error), 0);
    chk("rst busy", 32'(bus.busy), 0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int v = 0; v < 6; v++) begin
      bus.Prescale = 6'(vecs[v].ps);
      bus.PAR_EN   = vecs[v].pen;
      bus.PAR_TYP  = vecs[v].ptyp;
      dv0 = dv_cnt;
      send_frame(vecs[v].ps, vecs[v].d, vecs[v].pen, vecs[v].pbit, vecs[v].sbit,
                 vecs[v].ps_mid, vecs[v].pen_mid);
      repeat (3) @(negedge CLK);
      chk($sformatf("v%0d pulses", v), 32'(dv_cnt - dv0), 32'(vecs[v].exp_dv));
      chk($sformatf("v%0d P_DATA", v), 32'(bus.P_DATA), 32'(vecs[v].exp_pd));
      chk($sformatf("v%0d parity_error", v), 32'(bus.parity_error), 32'(vecs[v].exp_pe));
      chk($sformatf("v%0d stop_error", v), 32'(bus.stop_error), 32'(vecs[v].exp_se));
      chk($sformatf("v%0d busy", v), 32'(bus.busy), 0);
    end

    // Start glitch: line low for two cycles only.
    bus.Prescale = 6'd8;
    bus.PAR_EN = 1'b0;
    cur_ps = 8;
    dv0 = dv_cnt;
    bus.RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    chk("glitch busy in start", 32'(bus.busy), 1);
    chk("glitch smp_clear in start", 32'(bus.smp_clear), 0);
    bus.RX_IN = 1'b1;
    repeat (8) @(negedge CLK);
    chk("glitch busy", 32'(bus.busy), 0);
    chk("glitch sample_counter", 32'(bus.sample_counter), 0);
    chk("glitch bit_counter", 32'(bus.bit_counter), 0);
    chk("glitch smp_clear", 32'(bus.smp_clear), 1);
    chk("glitch flags", 32'({bus.parity_error, bus.stop_error}), 0);
    chk("glitch pulses", 32'(dv_cnt - dv0), 0);

    // Back-to-back frames without an idle gap.
    dv0 = dv_cnt;
    send_frame(8, 8'h55, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8, 8'hAA, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    repeat (4) @(negedge CLK);
    chk("b2b pulses", 32'(dv_cnt - dv0), 2);
    chk("b2b first byte", 32'(cap[dv0 % 16]), 32'h55);
    chk("b2b second byte", 32'(cap[(dv0 + 1) % 16]), 32'hAA);

    // Asynchronous reset two cycles into data bit 4.
    dv0 = dv_cnt;
    bus.RX_IN = 1'b0;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      bus.RX_IN = 1'(i % 2);
      repeat (8) @(negedge CLK);
    end
    bus.RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("pre-reset bit_counter", 32'(bus.bit_counter), 5);
    chk("pre-reset sample_counter", 32'(bus.sample_counter), 2);
    #1 RST = 1'b0;
    #1;
    chk("arst sample_counter", 32'(bus.sample_counter), 0);
    chk("arst bit_counter", 32'(bus.bit_counter), 0);
    chk("arst smp_clear", 32'(bus.smp_clear), 1);
    chk("arst P_DATA", 32'(bus.P_DATA), 0);
    chk("arst flags", 32'({bus.data_valid, bus.parity_error, bus.stop_error}), 0);
    chk("arst busy", 32'(bus.busy), 0);
    #1 RST = 1'b1;
    repeat (4) @(negedge CLK);
    chk("arst no pulse", 32'(dv_cnt - dv0), 0);
    send_frame(8, 8'h0F, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    repeat (3) @(negedge CLK);
    chk("post-reset pulses", 32'(dv_cnt - dv0), 1);
    chk("post-reset P_DATA", 32'(bus.P_DATA), 32'h0F);
    chk("post-reset busy", 32'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Frame-level controller for the UART receiver.
- Detects the start edge on RX_IN and runs the oversampling edge counter and bit counter that drive the 3-point majority data sampler.
- Consumes the sampler's bit/valid output, then assembles, checks and presents received bytes.
- Sits in the UART RX top between the synchronized RX line and the system-side data/valid consumer.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_WIDTH, 6, width of Prescale and sample_counter
COUNTER_WIDTH, 4, width of bit_counter

Ports:
CLK  input  1  UART RX oversampling clock
RST  input  1  reset; asynchronous, active-low
RX_IN  input  1  synchronized serial line, idle high
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
Prescale  input  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32
sampled_bit  input  1  majority bit from sampler
valid_sampled_bit  input  1  one-cycle strobe; sampled_bit is valid
sample_counter  output  PRESCALE_WIDTH  edge count within current bit, to sampler
bit_counter  output  COUNTER_WIDTH  bit index within frame (0 = start), to sampler
smp_clear  output  1  to sampler data_sampling_enable; high holds sampler cleared
P_DATA  output  DATA_WIDTH  last good byte, LSB received first
data_valid  output  1  one-cycle pulse, P_DATA updated
parity_error  output  1  parity mismatch on last frame
stop_error  output  1  stop bit sampled 0 on last frame
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: sample_counter 0, bit_counter 0, smp_clear 1, P_DATA 0, data_valid 0, parity_error 0, stop_error 0, busy 0. State = IDLE, shift register 0.
- Reset mid-frame aborts the frame immediately. No data_valid is issued.
- States: IDLE, START, DATA, PARITY, STOP.
- Prescale, PAR_EN and PAR_TYP are latched on the IDLE->START transition. Changes mid-frame are ignored.
- Counters:
  - In IDLE both counters are held at 0.
  - Otherwise sample_counter increments every cycle.
  - At Prescale-1, sample_counter wraps to 0 and bit_counter increments, except on the final bit of the frame.
- smp_clear = 1 in IDLE and 0 in all other states, registered. It goes low in the cycle the FSM enters START.
- IDLE: when RX_IN = 0, go to START. On that same transition, clear parity_error and stop_error.
- START:
  - On valid_sampled_bit with sampled_bit = 1 (glitch), return to IDLE. Counters reset, no flags change.
  - Otherwise, at sample_counter = Prescale-1, go to DATA.
- DATA:
  - On each valid_sampled_bit, shift sampled_bit into the MSB of the shift register (shift right). Bits therefore land LSB-first.
  - When bit_counter = DATA_WIDTH and sample_counter = Prescale-1, go to PARITY if PAR_EN, else STOP.
- PARITY:
  - On valid_sampled_bit, compare against the expected parity: XOR of shift register, inverted when PAR_TYP = 1.
  - Mismatch sets parity_error to 1 at the next edge.
  - At end of bit, go to STOP.
- STOP:
  - On valid_sampled_bit with sampled_bit = 0, set stop_error.
  - At sample_counter = Prescale-1 of the stop bit, go to IDLE.
  - On that same edge, if neither error is set and the stop bit sampled 1: P_DATA <= shift register and data_valid = 1 for exactly one cycle.
  - On any error, P_DATA holds its previous value and no pulse is issued.
- Back-to-back frames: IDLE accepts RX_IN = 0 in the first cycle after STOP. The resulting 1-cycle alignment offset is within sampler tolerance.
- Error flags persist until the next start detection or reset.
- A valid_sampled_bit arriving in IDLE is ignored.
- Counter widths: comparisons use the latched Prescale. Prescale-1 is computed in PRESCALE_WIDTH bits.

Test Plan:
- Prescale = 8, PAR_EN = 0, serial 0xA5 with stop = 1 -> one data_valid pulse, P_DATA = 0xA5, both errors 0, busy low 1 cycle after pulse.
- Prescale = 16, PAR_EN = 1, PAR_TYP = 0, byte 0x3C, parity bit 0 -> P_DATA = 0x3C, parity_error 0. Repeat with parity bit 1 -> parity_error 1, no data_valid, P_DATA unchanged.
- Prescale = 32, PAR_TYP = 1, byte 0x01, correct odd parity bit 0, stop bit 0 -> stop_error 1, no data_valid.
- RX_IN low for 2 cycles then high, Prescale = 8 -> sampler reports 1 in START, FSM returns to IDLE, counters 0, no flags.
- Two frames 0x55 and 0xAA back-to-back, no idle gap -> two data_valid pulses with P_DATA 0x55 then 0xAA.
- RST asserted during DATA bit 4 -> all outputs at reset values asynchronously. Next full frame 0x0F is received correctly.
